pss_search_ctrl: RTL

Search/track controller placed after the PSS correlator. It consumes the correlator magnitude stream with one value per input sample. In SEARCH it finds the first above-threshold correlation peak. It then switches to TRACK, which evaluates only a ±WINDOW sample window around each expected SSB burst position, PERIOD samples apart, and drops back to SEARCH after MISS_MAX consecutive empty windows. For every accepted peak it emits one detection beat carrying the peak magnitude and the sample index.

---
 rtl/pss_search_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pss_search_ctrl.sv
// PSS correlator peak search / periodic-window tracking controller.
// Optional build macro PSS_CTRL_DRIFT_EN: re-anchor the tracking grid on every hit.
module pss_search_ctrl #(
  parameter int unsigned C_DW     = 24,
  parameter int unsigned CNT_DW   = 17,
  parameter int unsigned PERIOD   = 76800,
  parameter int unsigned WINDOW   = 64,
  parameter int unsigned PEAK_WIN = 16,
  parameter int unsigned MISS_MAX = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [C_DW-1:0]        threshold_i,
  input  logic [C_DW-1:0]        s_axis_corr_tdata,
  input  logic                   s_axis_corr_tvalid,
  output logic [C_DW+CNT_DW-1:0] m_axis_det_tdata,
  output logic                   m_axis_det_tuser,
  output logic                   m_axis_det_tvalid,
  output logic [1:0]             state_o,
  output logic                   locked_o
);

  localparam int unsigned HOLD_W = $clog2(PEAK_WIN + 1);
  localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);
  localparam int unsigned DET_W  = C_DW + CNT_DW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_TRACK  = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PEAK_WIN - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [CNT_DW-1:0] CNT_ONE   = CNT_DW'(1);
  localparam logic [CNT_DW-1:0] WIN_LO    = CNT_DW'(PERIOD - WINDOW);
  localparam logic [CNT_DW-1:0] WIN_HI    = CNT_DW'(PERIOD + WINDOW);
  localparam logic [CNT_DW-1:0] D_AFTER   = CNT_DW'(WINDOW + 1);
`ifdef PSS_CTRL_DRIFT_EN
  localparam logic [CNT_DW-1:0] D_REANCHOR = CNT_DW'(PERIOD + WINDOW + 1);
`endif

  logic [1:0]        state_q, state_nxt;
  logic              start_q;
  logic [CNT_DW-1:0] samp_q, samp_nxt;
  logic [CNT_DW-1:0] d_q, d_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;
  logic [MISS_W-1:0] miss_q, miss_nxt;
  logic              cand_q, cand_nxt;
  logic [C_DW-1:0]   max_val_q, max_val_nxt;
  logic [CNT_DW-1:0] max_idx_q, max_idx_nxt;
`ifdef PSS_CTRL_DRIFT_EN
  logic [CNT_DW-1:0] max_d_q, max_d_nxt, md;
`endif
  logic [DET_W-1:0]  det_data_q, det_data_nxt;
  logic              det_user_q, det_user_nxt;
  logic              det_valid_q, det_valid_nxt;
  logic              locked_q, locked_nxt;

  logic              exceed_c;
  logic              start_rise_c;
  logic              in_win;
  logic              take;
  logic [C_DW-1:0]   mv;
  logic [CNT_DW-1:0] mi;

  assign exceed_c     = s_axis_corr_tdata > threshold_i;
  assign start_rise_c = start_i & ~start_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      samp_q      <= '0;
      d_q         <= '0;
      hold_q      <= '0;
      miss_q      <= '0;
      cand_q      <= 1'b0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
`ifdef PSS_CTRL_DRIFT_EN
      max_d_q     <= '0;
`endif
      det_data_q  <= '0;
      det_user_q  <= 1'b0;
      det_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      start_q     <= start_i;
      samp_q      <= samp_nxt;
      d_q         <= d_nxt;
      hold_q      <= hold_nxt;
      miss_q      <= miss_nxt;
      cand_q      <= cand_nxt;
      max_val_q   <= max_val_nxt;
      max_idx_q   <= max_idx_nxt;
`ifdef PSS_CTRL_DRIFT_EN
      max_d_q     <= max_d_nxt;
`endif
      det_data_q  <= det_data_nxt;
      det_user_q  <= det_user_nxt;
      det_valid_q <= det_valid_nxt;
      locked_q    <= locked_nxt;
    end
  end

  // Next-state, counters and detection beat
  always_comb begin
    state_nxt     = state_q;
    samp_nxt      = samp_q;
    d_nxt         = d_q;
    hold_nxt      = hold_q;
    miss_nxt      = miss_q;
    cand_nxt      = cand_q;
    max_val_nxt   = max_val_q;
    max_idx_nxt   = max_idx_q;
`ifdef PSS_CTRL_DRIFT_EN
    max_d_nxt     = max_d_q;
    md            = max_d_q;
`endif
    det_data_nxt  = '0;
    det_user_nxt  = 1'b0;
    det_valid_nxt = 1'b0;
    in_win        = 1'b0;
    take          = 1'b0;
    mv            = max_val_q;
    mi            = max_idx_q;

    if (stop_i || !(state_q == S_SEARCH || state_q == S_TRACK)) begin
      // IDLE (or stop): everything held cleared; stop overrides start
      state_nxt   = (!stop_i && state_q == S_IDLE && start_rise_c) ? S_SEARCH : S_IDLE;
      samp_nxt    = '0;
      d_nxt       = '0;
      hold_nxt    = '0;
      miss_nxt    = '0;
      cand_nxt    = 1'b0;
      max_val_nxt = '0;
      max_idx_nxt = '0;
`ifdef PSS_CTRL_DRIFT_EN
      max_d_nxt   = '0;
`endif
    end else if (s_axis_corr_tvalid) begin
      samp_nxt = samp_q + CNT_ONE;
      case (state_q)
        S_SEARCH: begin
          if (cand_q || exceed_c) begin
            take = exceed_c && (!cand_q || s_axis_corr_tdata > max_val_q);
            if (take) begin
              mv = s_axis_corr_tdata;
              mi = samp_q;
            end
            if (hold_q == HOLD_LAST) begin
              // Hold complete: report and anchor the tracking grid on the peak
              det_valid_nxt = 1'b1;
              det_data_nxt  = {mv, mi};
              state_nxt     = S_TRACK;
              d_nxt         = samp_q - mi + CNT_ONE;
              hold_nxt      = '0;
              miss_nxt      = '0;
              cand_nxt      = 1'b0;
              max_val_nxt   = '0;
              max_idx_nxt   = '0;
            end else begin
              hold_nxt    = hold_q + HOLD_ONE;
              cand_nxt    = 1'b1;
              max_val_nxt = mv;
              max_idx_nxt = mi;
            end
          end
        end
        S_TRACK: begin
          d_nxt  = d_q + CNT_ONE;
          in_win = (d_q >= WIN_LO) && (d_q <= WIN_HI);
          take   = in_win && exceed_c && (!cand_q || s_axis_corr_tdata > max_val_q);
          if (take) begin
            mv = s_axis_corr_tdata;
            mi = samp_q;
`ifdef PSS_CTRL_DRIFT_EN
            md = d_q;
`endif
          end
          if (d_q == WIN_HI) begin
            cand_nxt    = 1'b0;
            max_val_nxt = '0;
            max_idx_nxt = '0;
`ifdef PSS_CTRL_DRIFT_EN
            max_d_nxt   = '0;
`endif
            if (cand_q || take) begin
              det_valid_nxt = 1'b1;
              det_user_nxt  = 1'b1;
              det_data_nxt  = {mv, mi};
              miss_nxt      = '0;
`ifdef PSS_CTRL_DRIFT_EN
              d_nxt         = D_REANCHOR - md;
`else
              d_nxt         = D_AFTER;
`endif
            end else if (miss_q == MISS_LAST) begin
              state_nxt = S_SEARCH;
              miss_nxt  = '0;
              d_nxt     = '0;
              hold_nxt  = '0;
            end else begin
              // Empty window: step the reference virtually by one period
              miss_nxt = miss_q + MISS_ONE;
              d_nxt    = D_AFTER;
            end
          end else begin
            cand_nxt    = cand_q || take;
            max_val_nxt = mv;
            max_idx_nxt = mi;
`ifdef PSS_CTRL_DRIFT_EN
            max_d_nxt   = md;
`endif
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign locked_nxt = (state_nxt == S_TRACK);

  assign m_axis_det_tdata  = det_data_q;
  assign m_axis_det_tuser  = det_user_q;
  assign m_axis_det_tvalid = det_valid_q;
  assign state_o           = state_q;
  assign locked_o          = locked_q;

endmodule
